// File: rtl/me_pkg.sv
// rtl/me_pkg.sv - shared types and constants for the SAD best-select block
package me_pkg;

  localparam int NUM_CB    = 4;
  localparam int PKG_SAD_W = 16;
  localparam int PKG_COL_W = 5;
  localparam int PKG_ROW_W = 7;

  localparam logic [PKG_SAD_W-1:0] SAD_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [PKG_SAD_W-1:0] sad;
    logic [PKG_COL_W-1:0] mv_x;
    logic [PKG_ROW_W-1:0] mv_y;
  } best_t;

endpackage

// File: rtl/sad_best_reg.sv
// rtl/sad_best_reg.sv - single sub-block minimum-SAD tracker
module sad_best_reg
  import me_pkg::*;
#(
  parameter int SAD_W = 16,
  parameter int COL_W = 5,
  parameter int ROW_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             upd_i,
  input  logic [SAD_W-1:0] sad_i,
  input  logic [COL_W-1:0] col_i,
  input  logic [ROW_W-1:0] row_i,
  output logic [SAD_W-1:0] sad_nxt_o,
  output logic [COL_W-1:0] mv_x_nxt_o,
  output logic [ROW_W-1:0] mv_y_nxt_o
);

  logic [SAD_W-1:0] sad_q, sad_d;
  logic [COL_W-1:0] mv_x_q, mv_x_d;
  logic [ROW_W-1:0] mv_y_q, mv_y_d;

  // Strict less-than keeps the earlier position on ties.
  always_comb begin
    sad_d  = sad_q;
    mv_x_d = mv_x_q;
    mv_y_d = mv_y_q;
    if (clear_i) begin
      sad_d  = '1;
      mv_x_d = '0;
      mv_y_d = '0;
    end else if (upd_i && (sad_i < sad_q)) begin
      sad_d  = sad_i;
      mv_x_d = col_i;
      mv_y_d = row_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sad_q  <= '1;
      mv_x_q <= '0;
      mv_y_q <= '0;
    end else begin
      sad_q  <= sad_d;
      mv_x_q <= mv_x_d;
      mv_y_q <= mv_y_d;
    end
  end

  // Exposing next-state lets the top load a result that includes this cycle's sample.
  assign sad_nxt_o  = sad_d;
  assign mv_x_nxt_o = mv_x_d;
  assign mv_y_nxt_o = mv_y_d;

endmodule

// File: rtl/me_sad_best_select.sv
// rtl/me_sad_best_select.sv - per-sub-block minimum SAD tracking and result drain
module me_sad_best_select
  import me_pkg::*;
#(
  parameter int SAD_W = 16,
  parameter int COL_W = 5,
  parameter int ROW_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             frame_end,
  input  logic             sad_valid,
  input  logic [SAD_W-1:0] sad_in,
  input  logic [1:0]       abs_Control,
  input  logic [COL_W-1:0] search_column_count,
  input  logic [ROW_W-1:0] search_row_count,
  input  logic             result_ready,
  output logic             result_valid,
  output logic [1:0]       result_cb,
  output logic [COL_W-1:0] result_mv_x,
  output logic [ROW_W-1:0] result_mv_y,
  output logic [SAD_W-1:0] result_sad,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [1:0]       drain_idx_q, drain_idx_d;
  logic             valid_q, valid_d;
  logic [1:0]       cb_q, cb_d;
  logic [COL_W-1:0] mv_x_q, mv_x_d;
  logic [ROW_W-1:0] mv_y_q, mv_y_d;
  logic [SAD_W-1:0] sad_q, sad_d;
  logic             busy_q, busy_d;

  logic             trk_clear;
  logic             trk_upd;
  logic [SAD_W-1:0] trk_sad  [NUM_CB];
  logic [COL_W-1:0] trk_mv_x [NUM_CB];
  logic [ROW_W-1:0] trk_mv_y [NUM_CB];

  assign trk_clear = frame_start && (state_q != ST_DRAIN);
  assign trk_upd   = (state_q == ST_TRACK) && sad_valid && !frame_start;

  for (genvar g = 0; g < NUM_CB; g++) begin : g_trk
    sad_best_reg #(
      .SAD_W(SAD_W),
      .COL_W(COL_W),
      .ROW_W(ROW_W)
    ) u_best (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear_i    (trk_clear),
      .upd_i      (trk_upd && (abs_Control == 2'(g))),
      .sad_i      (sad_in),
      .col_i      (search_column_count),
      .row_i      (search_row_count),
      .sad_nxt_o  (trk_sad[g]),
      .mv_x_nxt_o (trk_mv_x[g]),
      .mv_y_nxt_o (trk_mv_y[g])
    );
  end

  // Trackers are frozen in DRAIN, so their next-state equals their stored value there.
  always_comb begin
    state_d     = state_q;
    drain_idx_d = drain_idx_q;
    valid_d     = valid_q;
    cb_d        = cb_q;
    mv_x_d      = mv_x_q;
    mv_y_d      = mv_y_q;
    sad_d       = sad_q;
    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          state_d     = ST_TRACK;
          drain_idx_d = 2'd0;
        end
      end
      ST_TRACK: begin
        if (frame_start) begin
          drain_idx_d = 2'd0;
        end else if (frame_end) begin
          state_d     = ST_DRAIN;
          drain_idx_d = 2'd0;
          valid_d     = 1'b1;
          cb_d        = 2'd0;
          mv_x_d      = trk_mv_x[0];
          mv_y_d      = trk_mv_y[0];
          sad_d       = trk_sad[0];
        end
      end
      ST_DRAIN: begin
        if (result_ready) begin
          if (drain_idx_q == 2'd3) begin
            state_d     = ST_IDLE;
            drain_idx_d = 2'd0;
            valid_d     = 1'b0;
            cb_d        = 2'd0;
            mv_x_d      = '0;
            mv_y_d      = '0;
            sad_d       = '0;
          end else begin
            drain_idx_d = drain_idx_q + 2'd1;
            cb_d        = drain_idx_d;
            mv_x_d      = trk_mv_x[drain_idx_d];
            mv_y_d      = trk_mv_y[drain_idx_d];
            sad_d       = trk_sad[drain_idx_d];
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      drain_idx_q <= 2'd0;
      valid_q     <= 1'b0;
      cb_q        <= 2'd0;
      mv_x_q      <= '0;
      mv_y_q      <= '0;
      sad_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_idx_q <= drain_idx_d;
      valid_q     <= valid_d;
      cb_q        <= cb_d;
      mv_x_q      <= mv_x_d;
      mv_y_q      <= mv_y_d;
      sad_q       <= sad_d;
      busy_q      <= busy_d;
    end
  end

  assign result_valid = valid_q;
  assign result_cb    = cb_q;
  assign result_mv_x  = mv_x_q;
  assign result_mv_y  = mv_y_q;
  assign result_sad   = sad_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_me_sad_best_select.sv
// tb/tb_me_sad_best_select.sv - scoreboard bench for me_sad_best_select
module tb_me_sad_best_select;
  import me_pkg::*;

  localparam int SAD_W = 16;
  localparam int COL_W = 5;
  localparam int ROW_W = 7;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             frame_start = 1'b0;
  logic             frame_end = 1'b0;
  logic             sad_valid = 1'b0;
  logic [SAD_W-1:0] sad_in = '0;
  logic [1:0]       abs_Control = '0;
  logic [COL_W-1:0] search_column_count = '0;
  logic [ROW_W-1:0] search_row_count = '0;
  logic             result_ready = 1'b0;
  logic             result_valid;
  logic [1:0]       result_cb;
  logic [COL_W-1:0] result_mv_x;
  logic [ROW_W-1:0] result_mv_y;
  logic [SAD_W-1:0] result_sad;
  logic             busy;

  typedef struct {
    logic [1:0]       cb;
    logic [COL_W-1:0] x;
    logic [ROW_W-1:0] y;
    logic [SAD_W-1:0] sad;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;
  int   n_tests = 0;
  int   n_fail = 0;

  me_sad_best_select #(
    .SAD_W(SAD_W),
    .COL_W(COL_W),
    .ROW_W(ROW_W)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .frame_start         (frame_start),
    .frame_end           (frame_end),
    .sad_valid           (sad_valid),
    .sad_in              (sad_in),
    .abs_Control         (abs_Control),
    .search_column_count (search_column_count),
    .search_row_count    (search_row_count),
    .result_ready        (result_ready),
    .result_valid        (result_valid),
    .result_cb           (result_cb),
    .result_mv_x         (result_mv_x),
    .result_mv_y         (result_mv_y),
    .result_sad          (result_sad),
    .busy                (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] cb, input logic [SAD_W-1:0] sad,
                      input logic [COL_W-1:0] x, input logic [ROW_W-1:0] y);
    exp_t e;
    e.cb = cb; e.sad = sad; e.x = x; e.y = y;
    exp_q.push_back(e);
  endtask

  task automatic smp(input logic [1:0] cb, input logic [SAD_W-1:0] sad,
                     input logic [COL_W-1:0] col, input logic [ROW_W-1:0] row);
    sad_valid = 1'b1; abs_Control = cb; sad_in = sad;
    search_column_count = col; search_row_count = row;
    step();
    sad_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int cyc;
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (busy && cyc < 12);
    check(name, cyc, 4);
  endtask

  // Monitor: compares every accepted result against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && result_valid && result_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'(result_cb), 32'hDEAD);
        end else begin
          e_mon = exp_q.pop_front();
          check("result_cb",   32'(result_cb),   32'(e_mon.cb));
          check("result_sad",  32'(result_sad),  32'(e_mon.sad));
          check("result_mv_x", 32'(result_mv_x), 32'(e_mon.x));
          check("result_mv_y", 32'(result_mv_y), 32'(e_mon.y));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step();
    check("rst_valid", 32'(result_valid), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_cb",    32'(result_cb), 0);
    check("rst_sad",   32'(result_sad), 0);
    rst_n = 1'b1;
    step();
    check("idle_busy", 32'(busy), 0);

    // Basic min, tie, simultaneous end, backpressure
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("start_busy",  32'(busy), 1);
    check("start_valid", 32'(result_valid), 0);
    smp(2'd1, 16'd500, 5'd3, 7'd10);
    smp(2'd1, 16'd200, 5'd4, 7'd12);
    smp(2'd1, 16'd300, 5'd5, 7'd2);
    smp(2'd2, 16'd100, 5'd6, 7'd20);
    smp(2'd2, 16'd100, 5'd7, 7'd21);
    push(2'd0, 16'hFFFF, 5'd0,  7'd0);
    push(2'd1, 16'd200,  5'd4,  7'd12);
    push(2'd2, 16'd100,  5'd6,  7'd20);
    push(2'd3, 16'd50,   5'd30, 7'd63);
    result_ready = 1'b0;
    frame_end = 1'b1;
    sad_valid = 1'b1; abs_Control = 2'd3; sad_in = 16'd50;
    search_column_count = 5'd30; search_row_count = 7'd63;
    step();
    frame_end = 1'b0;
    sad_valid = 1'b0;
    check("end_valid", 32'(result_valid), 1);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(result_valid), 1);
      check("bp_cb",    32'(result_cb), 0);
      check("bp_sad",   32'(result_sad), 32'hFFFF);
      check("bp_mv",    {20'd0, 5'(result_mv_x), 7'(result_mv_y)}, 0);
      // inputs that must be ignored while draining
      sad_valid = 1'b1; abs_Control = 2'd1; sad_in = 16'd1; frame_start = 1'b1;
      step();
    end
    sad_valid = 1'b0;
    frame_start = 1'b0;
    result_ready = 1'b1;
    wait_drain("drain1_cycles");
    check("drain1_valid", 32'(result_valid), 0);
    check("drain1_q", 32'(exp_q.size()), 0);

    // Restart mid-TRACK, frame_start beats frame_end
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    smp(2'd0, 16'd10, 5'd1, 7'd1);
    frame_start = 1'b1;
    frame_end = 1'b1;
    step();
    frame_start = 1'b0;
    frame_end = 1'b0;
    check("restart_busy",  32'(busy), 1);
    check("restart_valid", 32'(result_valid), 0);
    smp(2'd0, 16'd40, 5'd2, 7'd2);
    push(2'd0, 16'd40,   5'd2, 7'd2);
    push(2'd1, 16'hFFFF, 5'd0, 7'd0);
    push(2'd2, 16'hFFFF, 5'd0, 7'd0);
    push(2'd3, 16'hFFFF, 5'd0, 7'd0);
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
    wait_drain("drain2_cycles");

    // Reset mid-DRAIN drops the pending results
    result_ready = 1'b0;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    smp(2'd1, 16'd7, 5'd1, 7'd2);
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
    check("rd_valid", 32'(result_valid), 1);
    step();
    rst_n = 1'b0;
    #1;
    check("rd_rst_valid", 32'(result_valid), 0);
    check("rd_rst_busy",  32'(busy), 0);
    check("rd_rst_sad",   32'(result_sad), 0);
    check("rd_rst_fields", {23'd0, 2'(result_cb), 7'(result_mv_y)} | 32'(result_mv_x), 0);
    step();
    rst_n = 1'b1;
    step();
    check("rd_idle_busy",  32'(busy), 0);
    check("rd_idle_valid", 32'(result_valid), 0);

    // Empty frame after reset: every sub-block reports SAD_MAX at (0,0)
    result_ready = 1'b1;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    for (int i = 0; i < NUM_CB; i++) push(2'(i), SAD_MAX, 5'd0, 7'd0);
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
    wait_drain("drain3_cycles");
    step();
    check("final_q_empty", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
